// File: rtl/nco_core.sv
// nco_core: 64-bit phase-accumulator NCO producing a registered waveform sample, a PWM bit and a wrap strobe.
// Optional macro NCO_LOAD_ON_WRAP_EN: settings reload only at period boundaries (or while disabled).
module nco_core #(
    parameter int ACC_W = 64,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ACC_W-1:0] frequency,
    input  logic [15:0]      duty_cycle,
    input  logic [1:0]       wave,
    input  logic             enable,
    output logic [OUT_W-1:0] wave_out,
    output logic             pwm_out,
    output logic             wrap,
    output logic             active
);

    localparam logic [1:0] WAVE_SQUARE   = 2'b00;
    localparam logic [1:0] WAVE_SAWTOOTH = 2'b01;
    localparam logic [1:0] WAVE_TRIANGLE = 2'b10;
    localparam logic [1:0] WAVE_RAMPDOWN = 2'b11;

    logic             cfg_en;
    logic [ACC_W-1:0] cfg_freq;
    logic [15:0]      cfg_duty;
    logic [1:0]       cfg_wave;
    logic             cfg_load;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;

`ifdef NCO_LOAD_ON_WRAP_EN
    // Retune only at a period boundary so a multi-byte update never produces a glitch.
    assign cfg_load = wrap || !cfg_en;
`else
    assign cfg_load = 1'b1;
`endif

    // Stage 0: settings capture.
    // NOTE: every register here is state, so it uses non-blocking assignment and clears on the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_en   <= 1'b0;
            cfg_freq <= '0;
            cfg_duty <= '0;
            cfg_wave <= WAVE_SQUARE;
        end else begin
            cfg_en <= enable;
            if (cfg_load) begin
                cfg_freq <= frequency;
                cfg_duty <= duty_cycle;
                cfg_wave <= wave;
            end
        end
    end

    // Stage 1: accumulator; the extra sum bit is the carry that becomes the wrap strobe.
    assign acc_sum = {1'b0, acc} + {1'b0, cfg_freq};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            wrap   <= 1'b0;
            active <= 1'b0;
        end else begin
            active <= cfg_en;
            if (cfg_en) begin
                acc  <= acc_sum[ACC_W-1:0];
                wrap <= acc_sum[ACC_W];
            end else begin
                acc  <= '0;
                wrap <= 1'b0;
            end
        end
    end

    // Stage 2: waveform shaping from the current phase.
    logic [OUT_W-1:0] phase;
    logic [15:0]      phase_duty;
    logic             pwm;
    logic [OUT_W-1:0] tri_wave;
    logic [OUT_W-1:0] sample;

    assign phase      = acc[ACC_W-1 -: OUT_W];
    assign phase_duty = acc[ACC_W-1 -: 16];
    assign pwm        = (phase_duty < cfg_duty);
    assign tri_wave   = phase[OUT_W-1] ? ~{phase[OUT_W-2:0], 1'b0} : {phase[OUT_W-2:0], 1'b0};

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        sample = '0;
        case (cfg_wave)
            WAVE_SQUARE:   sample = {OUT_W{pwm}};
            WAVE_SAWTOOTH: sample = phase;
            WAVE_TRIANGLE: sample = tri_wave;
            WAVE_RAMPDOWN: sample = ~phase;
            default:       sample = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wave_out <= '0;
            pwm_out  <= 1'b0;
        end else if (cfg_en) begin
            wave_out <= sample;
            pwm_out  <= pwm;
        end else begin
            wave_out <= '0;
            pwm_out  <= 1'b0;
        end
    end

endmodule
